sdram_port_responder: RTL and testbench
=======================================

# sdram_port_responder

Responder for the internal command/data/read-return interface that the Wishbone port drives on the `sdram_clk` side. Accepts 16-bit write commands with byte selects and line-read commands, and serves them from an on-chip 16-bit synchronous RAM. Read data is returned as a wrapping, critical-halfword-first burst with a programmable CAS-style latency. Used as an SDRAM stand-in for bring-up, simulation and on-chip scratch memory.

## Interface
- `BUF_WIDTH`, 3: log2 of the port's read buffer size in 32-bit words; burst length `BURST_LEN = 2^(BUF_WIDTH+1)` halfwords.
- `MEM_AW`, 12: log2 of RAM depth in halfwords.
- `CAS_LATENCY`, 2: cycles from read acceptance to the first returned beat; legal range 1..7.

- `sdram_clk` in 1: sole clock.
- `sdram_rst_n` in 1: one clock; reset is asynchronous and active-low.
- `ca_adr_i` in 32: byte address of the command; bit 0 ignored.
- `ca_we_i` in 1: 1 = write, 0 = line read.
- `ca_valid_i` in 1: command valid.
- `ca_ready_o` out 1: command accepted when `ca_valid_i & ca_ready_o`. The same signal also acts as write-data ready.
- `dm_dat_i` in 16: write halfword.
- `dm_sel_i` in 2: byte enables; bit 1 = [15:8], bit 0 = [7:0].
- `dm_valid_i` in 1: write data valid.
- `r_adr_o` out 32: byte address of the returned halfword.
- `r_dat_o` out 16: returned halfword.
- `r_valid_o` out 1: read beat valid. There is no backpressure; the consumer is always ready.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- RAM index: `idx = ca_adr_i[MEM_AW:1]`. Higher address bits alias; they are not decoded.
- States: IDLE, RD_WAIT, RD_BURST.
- `ca_ready_o = (state==IDLE) & (!ca_we_i | dm_valid_i)`. This is combinational, so a write is only accepted together with its data.

**Write** (IDLE, `ca_valid_i & ca_we_i & dm_valid_i`):
- Write `dm_dat_i` into `idx`, masked per byte by `dm_sel_i`. `dm_sel_i = 0` is a legal no-op.
- Remain in IDLE. Back-to-back writes run at one per cycle.

**Read** (IDLE, `ca_valid_i & !ca_we_i`):
- Latch the upper address `ca_adr_i[31:BUF_WIDTH+2]` and the start offset `off0 = ca_adr_i[BUF_WIDTH+1:1]`.
- Load the latency counter with `CAS_LATENCY-1`, then go to RD_WAIT. If `CAS_LATENCY = 1`, go directly to RD_BURST.
- RD_WAIT: decrement the counter each cycle; go to RD_BURST when it reaches 0.
- RD_BURST: emit `BURST_LEN` beats on consecutive cycles.
  - Beat k offset: `off = (off0+k) mod BURST_LEN`, so the burst wraps within the aligned line.
  - `r_adr_o = {latched upper, off, 1'b0}`.
  - `r_dat_o` = RAM[line base | off], where line base is `idx` with its low `BUF_WIDTH+1` bits cleared.
  - After the last beat, return to IDLE.
- Commands arriving during RD_WAIT or RD_BURST stall (ready low). They are not dropped.

**Ordering**
- A write accepted at edge T is visible to a read accepted at T+1 or later.

**Reset**
- Asynchronous assert, from any state including mid-burst:
  - state → IDLE; counters → 0.
  - `r_valid_o`, `r_dat_o`, `r_adr_o`, `busy_o` → 0.
  - `ca_ready_o` follows its IDLE equation.
- RAM contents are not cleared.
- Synchronous deassert is the integrator's responsibility.

## Timing
- Read accepted at edge T:
  - First beat is valid in the cycle after edge T+CAS_LATENCY-1. With `CAS_LATENCY = 2`, `r_valid_o` is high during cycles T+2 … T+2+BURST_LEN-1.
  - `r_valid_o` is high for exactly `BURST_LEN` contiguous cycles with no gaps.
  - `busy_o` goes high in the cycle after T and low in the cycle after the last beat.
  - `ca_ready_o` can be high again in that same cycle after the last beat.
- `r_adr_o`/`r_dat_o` are registered. They hold their last beat value while `r_valid_o` is low; the value is don't-care to consumers.
- Write latency to RAM is 1 edge. There is no write response.
- Read throughput: one line per `CAS_LATENCY + BURST_LEN` cycles.

## Test plan
1. **Reset state.** Assert `sdram_rst_n = 0` with `ca_valid_i = 0` → `r_valid_o = 0`, `busy_o = 0`, `r_adr_o = 0`, `r_dat_o = 0`, `ca_ready_o = 1`.
2. **Wrapping read.** Write halfwords 0x1000+i to byte addresses 0x40+2i for i = 0..15. Then read 0x4A with `BUF_WIDTH = 3`, `CAS_LATENCY = 2` → 16 beats.
   - `r_adr_o` sequence: 0x4A, 0x4C … 0x5E, 0x40 … 0x48.
   - Data sequence: 0x1005 … 0x100F, 0x1000 … 0x1004.
   - First beat arrives 2 cycles after acceptance.
3. **Byte masking.** Write 0xAAAA to 0x10 with sel=3, then 0x55xx with sel=2 → reading line 0x10 returns 0x55AA at `r_adr_o = 0x10`.
4. **Write without data.** Assert `ca_valid_i = 1`, `ca_we_i = 1`, `dm_valid_i = 0` for 3 cycles → `ca_ready_o = 0` and RAM unchanged. Raise `dm_valid_i` → accepted in that cycle.
5. **Stall during burst.** Issue a read, then hold a write valid during the burst → `ca_ready_o = 0` for all burst cycles. The write is accepted in the cycle after the last beat, and re-reading returns the new value.
6. **Reset mid-burst.** Assert reset at beat 5 → `r_valid_o` drops asynchronously and `busy_o = 0`. After release, a new read returns the RAM contents that were written before the reset.

Source files
------------

// File: rtl/sdram_port_responder.sv
// SDRAM stand-in: byte-masked halfword writes, wrapping critical-halfword-first line reads from on-chip RAM.
// Write takes 1 edge; first read beat appears CAS_LATENCY cycles after acceptance; commands stall while a read is in flight.
module sdram_port_responder #(
    parameter int BUF_WIDTH   = 3,
    parameter int MEM_AW      = 12,
    parameter int CAS_LATENCY = 2
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst_n,
    input  logic [31:0] ca_adr_i,
    input  logic        ca_we_i,
    input  logic        ca_valid_i,
    output logic        ca_ready_o,
    input  logic [15:0] dm_dat_i,
    input  logic [1:0]  dm_sel_i,
    input  logic        dm_valid_i,
    output logic [31:0] r_adr_o,
    output logic [15:0] r_dat_o,
    output logic        r_valid_o,
    output logic        busy_o
);

    localparam int OW        = BUF_WIDTH + 1;
    localparam int BURST_LEN = 1 << OW;
    localparam int UW        = 32 - OW - 1;
    localparam int LW        = MEM_AW - OW;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST} state_t;

    state_t          r_state;
    logic [2:0]      r_cnt;
    logic [OW:0]     r_beat;
    logic [UW-1:0]   r_upper;
    logic [OW-1:0]   r_off0;
    logic [LW-1:0]   r_line;
    logic [15:0]     r_mem [0:(1<<MEM_AW)-1];

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_emit;
    logic [MEM_AW-1:0] w_idx;
    logic [OW-1:0]     w_off;
    logic [LW-1:0]     w_line;
    logic [UW-1:0]     w_upper;
    logic              w_unused;

    assign w_unused   = ca_adr_i[0];
    assign ca_ready_o = (r_state == IDLE) & (!ca_we_i | dm_valid_i);
    assign w_wr_acc   = ca_valid_i & ca_ready_o & ca_we_i;
    assign w_rd_acc   = ca_valid_i & ca_ready_o & !ca_we_i;
    assign w_idx      = ca_adr_i[MEM_AW:1];
    assign busy_o     = (r_state != IDLE);

    // In IDLE the beat source is the incoming command (only used when CAS_LATENCY is 1).
    always_comb begin
        w_off   = r_off0 + r_beat[OW-1:0];
        w_line  = r_line;
        w_upper = r_upper;
        if (r_state == IDLE) begin
            w_off   = ca_adr_i[OW:1];
            w_line  = ca_adr_i[MEM_AW:OW+1];
            w_upper = ca_adr_i[31:OW+1];
        end
    end

    always_comb begin
        w_emit = 1'b0;
        case (r_state)
            IDLE:     w_emit = w_rd_acc && (CAS_LATENCY == 1);
            RD_WAIT:  w_emit = (r_cnt == 3'd1);
            RD_BURST: w_emit = (r_beat != (OW+1)'(BURST_LEN));
            default:  w_emit = 1'b0;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (w_wr_acc) begin
            if (dm_sel_i[0]) r_mem[w_idx][7:0]  <= dm_dat_i[7:0];
            if (dm_sel_i[1]) r_mem[w_idx][15:8] <= dm_dat_i[15:8];
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_beat    <= '0;
            r_upper   <= '0;
            r_off0    <= '0;
            r_line    <= '0;
            r_valid_o <= 1'b0;
            r_adr_o   <= 32'd0;
            r_dat_o   <= 16'd0;
        end else begin
            r_valid_o <= w_emit;
            if (w_emit) begin
                r_adr_o <= {w_upper, w_off, 1'b0};
                r_dat_o <= r_mem[{w_line, w_off}];
            end
            case (r_state)
                IDLE: begin
                    if (w_rd_acc) begin
                        r_upper <= ca_adr_i[31:OW+1];
                        r_off0  <= ca_adr_i[OW:1];
                        r_line  <= ca_adr_i[MEM_AW:OW+1];
                        r_cnt   <= 3'(CAS_LATENCY - 1);
                        if (CAS_LATENCY == 1) begin
                            r_beat  <= (OW+1)'(1);
                            r_state <= RD_BURST;
                        end else begin
                            r_beat  <= '0;
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    // Beat 0 leaves on the edge the counter expires, so RD_BURST starts at beat 1.
                    if (r_cnt == 3'd1) begin
                        r_beat  <= (OW+1)'(1);
                        r_state <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (r_beat == (OW+1)'(BURST_LEN)) begin
                        r_beat  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_responder.sv
// Directed bench for sdram_port_responder with BUF_WIDTH=3, MEM_AW=12, CAS_LATENCY=2.
module tb_sdram_port_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ca_adr_i;
    logic        ca_we_i;
    logic        ca_valid_i;
    logic        ca_ready_o;
    logic [15:0] dm_dat_i;
    logic [1:0]  dm_sel_i;
    logic        dm_valid_i;
    logic [31:0] r_adr_o;
    logic [15:0] r_dat_o;
    logic        r_valid_o;
    logic        busy_o;

    int nchk = 0;
    int nerr = 0;
    logic [15:0] shadow [0:4095];
    logic [31:0] first_adr, last_adr;
    logic [15:0] first_dat, last_dat;

    sdram_port_responder #(.BUF_WIDTH(3), .MEM_AW(12), .CAS_LATENCY(2)) dut (
        .sdram_clk  (clk),
        .sdram_rst_n(rst_n),
        .ca_adr_i   (ca_adr_i),
        .ca_we_i    (ca_we_i),
        .ca_valid_i (ca_valid_i),
        .ca_ready_o (ca_ready_o),
        .dm_dat_i   (dm_dat_i),
        .dm_sel_i   (dm_sel_i),
        .dm_valid_i (dm_valid_i),
        .r_adr_o    (r_adr_o),
        .r_dat_o    (r_dat_o),
        .r_valid_o  (r_valid_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic do_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] s);
        ca_adr_i = a; ca_we_i = 1'b1; ca_valid_i = 1'b1;
        dm_dat_i = d; dm_sel_i = s; dm_valid_i = 1'b1;
        tick();
        ca_valid_i = 1'b0; dm_valid_i = 1'b0; ca_we_i = 1'b0;
        if (s[0]) shadow[a[12:1]][7:0]  = d[7:0];
        if (s[1]) shadow[a[12:1]][15:8] = d[15:8];
    endtask

    task automatic issue_read(input logic [31:0] a);
        ca_adr_i = a; ca_we_i = 1'b0; ca_valid_i = 1'b1;
        tick();
        ca_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] beat_adr(input logic [31:0] a, input int k);
        logic [3:0] off;
        off = 4'(a[4:1] + 4'(k));
        return (a & 32'hFFFF_FFE0) | {27'd0, off, 1'b0};
    endfunction

    task automatic read_burst(input logic [31:0] a);
        logic [31:0] ea;
        issue_read(a);
        chk("rd_wait_valid", {31'd0, r_valid_o}, 32'd0);
        chk("rd_wait_busy", {31'd0, busy_o}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            ea = beat_adr(a, k);
            chk("beat_valid", {31'd0, r_valid_o}, 32'd1);
            chk("beat_adr", r_adr_o, ea);
            chk("beat_dat", {16'd0, r_dat_o}, {16'd0, shadow[ea[12:1]]});
            if (k == 0) begin first_adr = r_adr_o; first_dat = r_dat_o; end
            if (k == 15) begin last_adr = r_adr_o; last_dat = r_dat_o; end
        end
        tick();
        chk("post_valid", {31'd0, r_valid_o}, 32'd0);
        chk("post_busy", {31'd0, busy_o}, 32'd0);
        chk("post_ready", {31'd0, ca_ready_o}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ca_adr_i = '0; ca_we_i = 1'b0; ca_valid_i = 1'b0;
        dm_dat_i = '0; dm_sel_i = '0; dm_valid_i = 1'b0;
        #12;
        chk("rst_valid", {31'd0, r_valid_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_adr", r_adr_o, 32'd0);
        chk("rst_dat", {16'd0, r_dat_o}, 32'd0);
        chk("rst_ready", {31'd0, ca_ready_o}, 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) do_write(32'(2 * i), 16'(16'hC000 + i), 2'b11);
        for (int i = 0; i < 16; i++) do_write(32'(32'h40 + 2 * i), 16'(16'h1000 + i), 2'b11);

        // Wrapping read from 0x4A.
        read_burst(32'h4A);
        chk("wrap_first_adr", first_adr, 32'h4A);
        chk("wrap_first_dat", {16'd0, first_dat}, 32'h1005);
        chk("wrap_last_adr", last_adr, 32'h48);
        chk("wrap_last_dat", {16'd0, last_dat}, 32'h1004);

        // Byte masking.
        do_write(32'h10, 16'hAAAA, 2'b11);
        do_write(32'h10, 16'h5533, 2'b10);
        read_burst(32'h10);
        chk("mask_adr", first_adr, 32'h10);
        chk("mask_dat", {16'd0, first_dat}, 32'h55AA);

        // Write held without data.
        ca_adr_i = 32'h20; ca_we_i = 1'b1; ca_valid_i = 1'b1;
        dm_dat_i = 16'hDEAD; dm_sel_i = 2'b11; dm_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nodata_ready", {31'd0, ca_ready_o}, 32'd0);
            tick();
        end
        dm_valid_i = 1'b1;
        #1;
        chk("data_ready", {31'd0, ca_ready_o}, 32'd1);
        tick();
        ca_valid_i = 1'b0; dm_valid_i = 1'b0; ca_we_i = 1'b0;
        shadow[12'h10] = 16'hDEAD;
        read_burst(32'h20);
        chk("nodata_dat", {16'd0, first_dat}, 32'hDEAD);

        // Write stalled behind a burst.
        issue_read(32'h40);
        ca_adr_i = 32'h44; ca_we_i = 1'b1; ca_valid_i = 1'b1;
        dm_dat_i = 16'hBEEF; dm_sel_i = 2'b11; dm_valid_i = 1'b1;
        #1;
        chk("stall_wait_ready", {31'd0, ca_ready_o}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("stall_ready", {31'd0, ca_ready_o}, 32'd0);
            chk("stall_beat_adr", r_adr_o, beat_adr(32'h40, k));
        end
        tick();
        chk("stall_release_ready", {31'd0, ca_ready_o}, 32'd1);
        chk("stall_release_valid", {31'd0, r_valid_o}, 32'd0);
        tick();
        ca_valid_i = 1'b0; dm_valid_i = 1'b0; ca_we_i = 1'b0;
        shadow[12'h22] = 16'hBEEF;
        read_burst(32'h44);
        chk("stall_new_dat", {16'd0, first_dat}, 32'hBEEF);

        // Reset in the middle of a burst.
        issue_read(32'h00);
        for (int k = 0; k < 6; k++) tick();
        chk("mid_beat5_valid", {31'd0, r_valid_o}, 32'd1);
        chk("mid_beat5_adr", r_adr_o, 32'h0A);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, r_valid_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_adr", r_adr_o, 32'd0);
        chk("mid_rst_ready", {31'd0, ca_ready_o}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        read_burst(32'h06);
        chk("after_rst_dat", {16'd0, first_dat}, 32'hC003);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
